// File: rtl/guess_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_pkg
// Description : State encodings, hint codes and LFSR tap table for the engine.
// Revision    : 1.0 - initial release
// ============================================================================
package guess_game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ARM  = 3'd1;
    localparam state_t ST_PLAY = 3'd2;
    localparam state_t ST_WIN  = 3'd3;
    localparam state_t ST_LOSE = 3'd4;

    localparam logic [1:0] HINT_REJECT  = 2'b00;
    localparam logic [1:0] HINT_UP      = 2'b01;
    localparam logic [1:0] HINT_DOWN    = 2'b10;
    localparam logic [1:0] HINT_CORRECT = 2'b11;

    // Feedback taps (bit i set = stage i+1) of maximal-length polynomials.
    // Wider widths fall back to the top two stages, which still never lock at zero.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            32'd2:   taps = 32'h0000_0003;
            32'd3:   taps = 32'h0000_0006;
            32'd4:   taps = 32'h0000_000C;
            32'd5:   taps = 32'h0000_0014;
            32'd6:   taps = 32'h0000_0030;
            32'd7:   taps = 32'h0000_0060;
            32'd8:   taps = 32'h0000_00B8;
            32'd9:   taps = 32'h0000_0110;
            32'd10:  taps = 32'h0000_0240;
            32'd11:  taps = 32'h0000_0500;
            32'd12:  taps = 32'h0000_0829;
            32'd13:  taps = 32'h0000_100D;
            32'd14:  taps = 32'h0000_2015;
            32'd15:  taps = 32'h0000_6000;
            32'd16:  taps = 32'h0000_D008;
            default: taps = (width >= 32'd2) ? (32'h0000_0003 << (width - 32'd2)) : 32'h0000_0001;
        endcase
        return taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/guess_game_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_engine_if
// Description : Player-side control and result bus of the guessing engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface guess_game_engine_if #(
    parameter int WIDTH     = 7,
    parameter int MAX_TRIES = 8
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    logic               start;
    logic               guess_trigger;
    logic [WIDTH-1:0]   user_number;
    logic [1:0]         hint;
    logic               hint_valid;
    logic [TRIES_W-1:0] tries_left;
    logic               game_over;
    logic               win;
    logic [WIDTH-1:0]   actual_number;
    logic [2:0]         game_status;

    modport master (
        output start, guess_trigger, user_number,
        input  hint, hint_valid, tries_left, game_over, win, actual_number, game_status
    );

    modport slave (
        input  start, guess_trigger, user_number,
        output hint, hint_valid, tries_left, game_over, win, actual_number, game_status
    );
endinterface
`default_nettype wire

// File: rtl/guess_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : guess_lfsr
// Description : Free-running maximal-length Fibonacci LFSR used as target source.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_lfsr
    import guess_game_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_lfsr;

    generate
        if (WIDTH == 1) begin : g_single
            // A one-bit register has a single nonzero state, so it simply holds SEED.
            always_ff @(posedge clk) begin
                if (reset) r_lfsr <= SEED;
                else       r_lfsr <= r_lfsr;
            end
        end else begin : g_shift
            localparam logic [WIDTH-1:0] c_taps = WIDTH'(lfsr_taps(WIDTH));
            logic w_feedback;

            assign w_feedback = ^(r_lfsr & c_taps);

            always_ff @(posedge clk) begin
                if (reset) r_lfsr <= SEED;
                else       r_lfsr <= {r_lfsr[WIDTH-2:0], w_feedback};
            end
        end
    endgenerate

    assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/guess_game_engine.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_engine
// Description : Number-guessing round controller; optional bound tracking is
//               enabled with the GUESS_RANGE_NARROW_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_game_engine
    import guess_game_pkg::*;
#(
    parameter int               WIDTH     = 7,
    parameter int               MAX_TRIES = 8,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1)
) (
    input  logic               clk,
    input  logic               reset,
    guess_game_engine_if.slave bus
);

    localparam int                 TRIES_W     = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] c_max_tries = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] c_one_try   = TRIES_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   w_lfsr;
    logic [WIDTH-1:0]   r_target;
    logic [1:0]         r_hint;
    logic               r_hint_valid;
    logic [TRIES_W-1:0] r_tries;
    logic               w_guess_fire;
    logic               w_in_range;
    logic               w_correct;
    logic               w_target_above;
    logic               w_last_try;
    logic               w_game_over;
    logic               w_win;

    guess_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (w_lfsr)
    );

    // start pre-empts any guess presented in the same cycle
    assign w_guess_fire   = bus.guess_trigger && !bus.start && (r_state == ST_PLAY);
    assign w_correct      = (bus.user_number == r_target);
    assign w_target_above = (bus.user_number < r_target);
    assign w_last_try     = (r_tries == c_one_try);

`ifdef GUESS_RANGE_NARROW_EN
    localparam logic [WIDTH-1:0] c_lo_init = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_hi_init = '1;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    assign w_in_range = (bus.user_number >= r_lo) && (bus.user_number <= r_hi);
`else
    assign w_in_range = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.start) begin
            w_next_state = ST_ARM;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_IDLE;
                ST_ARM:  w_next_state = ST_PLAY;
                ST_PLAY: begin
                    if (w_guess_fire && w_in_range) begin
                        if (w_correct)       w_next_state = ST_WIN;
                        else if (w_last_try) w_next_state = ST_LOSE;
                    end
                end
                ST_WIN:  w_next_state = ST_WIN;
                ST_LOSE: w_next_state = ST_LOSE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_game_over = 1'b0;
        w_win       = 1'b0;
        case (r_state)
            ST_WIN:  begin w_game_over = 1'b1; w_win = 1'b1; end
            ST_LOSE: w_game_over = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_target     <= '0;
            r_hint       <= HINT_REJECT;
            r_hint_valid <= 1'b0;
            r_tries      <= '0;
`ifdef GUESS_RANGE_NARROW_EN
            r_lo         <= c_lo_init;
            r_hi         <= c_hi_init;
`endif
        end else begin
            r_hint_valid <= 1'b0;
            if (r_state == ST_ARM) begin
                r_target <= w_lfsr;
                r_tries  <= c_max_tries;
`ifdef GUESS_RANGE_NARROW_EN
                r_lo     <= c_lo_init;
                r_hi     <= c_hi_init;
`endif
            end
            if (w_guess_fire) begin
                r_hint_valid <= 1'b1;
                if (!w_in_range) begin
                    r_hint <= HINT_REJECT;
                end else begin
                    r_tries <= r_tries - c_one_try;
                    if (w_correct) begin
                        r_hint <= HINT_CORRECT;
                    end else if (w_target_above) begin
                        r_hint <= HINT_UP;
`ifdef GUESS_RANGE_NARROW_EN
                        r_lo   <= bus.user_number + WIDTH'(1);
`endif
                    end else begin
                        r_hint <= HINT_DOWN;
`ifdef GUESS_RANGE_NARROW_EN
                        r_hi   <= bus.user_number - WIDTH'(1);
`endif
                    end
                end
            end
        end
    end

    // A hint landing in a reset cycle belongs to an aborted round and is never reported.
    assign bus.hint_valid    = r_hint_valid & ~reset;
    assign bus.hint          = r_hint;
    assign bus.tries_left    = r_tries;
    assign bus.game_over     = w_game_over;
    assign bus.win           = w_win;
    assign bus.actual_number = r_target;
    assign bus.game_status   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_guess_game_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_game_engine
// Description : Directed vector bench driving a MAX_TRIES=8 and a MAX_TRIES=3
//               engine with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_game_engine;
    import guess_game_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       guess_trigger;
    logic [6:0] user_number;
    logic [6:0] m_lfsr;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    guess_game_engine_if #(.WIDTH(7), .MAX_TRIES(8)) bus8 ();
    guess_game_engine_if #(.WIDTH(7), .MAX_TRIES(3)) bus3 ();

    assign bus8.start         = start;
    assign bus8.guess_trigger = guess_trigger;
    assign bus8.user_number   = user_number;
    assign bus3.start         = start;
    assign bus3.guess_trigger = guess_trigger;
    assign bus3.user_number   = user_number;

    guess_game_engine #(.WIDTH(7), .MAX_TRIES(8), .SEED(7'd1)) dut8 (
        .clk (clk), .reset (reset), .bus (bus8)
    );
    guess_game_engine #(.WIDTH(7), .MAX_TRIES(3), .SEED(7'd1)) dut3 (
        .clk (clk), .reset (reset), .bus (bus3)
    );

    // x^7 + x^6 + 1 reference sequence
    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    always @(posedge clk) begin
        if (reset) m_lfsr <= 7'd1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    typedef struct {
        logic       new_round;
        logic       trig;
        logic [6:0] num;
        logic       hv8;
        logic [1:0] h8;
        logic [3:0] t8;
        logic       ov8;
        logic       w8;
        logic       hv3;
        logic [1:0] h3;
        logic [1:0] t3;
        logic       ov3;
        logic       w3;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_state(input logic ov, input logic w);
        return w ? ST_WIN : (ov ? ST_LOSE : ST_PLAY);
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, " status8"}, 32'(bus8.game_status), 32'(ST_IDLE));
        chk({tag, " status3"}, 32'(bus3.game_status), 32'(ST_IDLE));
        chk({tag, " hintcode_m8"}, 32'(bus8.hint), 32'(HINT_REJECT));
        chk({tag, " hv8"}, 32'(bus8.hint_valid), 32'd0);
        chk({tag, " hv3"}, 32'(bus3.hint_valid), 32'd0);
        chk({tag, " tries8"}, 32'(bus8.tries_left), 32'd0);
        chk({tag, " tries3"}, 32'(bus3.tries_left), 32'd0);
        chk({tag, " over8"}, 32'(bus8.game_over), 32'd0);
        chk({tag, " win8"}, 32'(bus8.win), 32'd0);
        chk({tag, " actual8"}, 32'(bus8.actual_number), 32'd0);
    endtask

    // Pulse start when the reference LFSR is one step away from tgt so tgt is latched.
    task automatic start_round(input logic [6:0] tgt);
        int waited = 0;
        while (lfsr_step(m_lfsr) != tgt && waited < 300) begin
            tick();
            waited++;
        end
        chk("round wait in bound", 32'(waited < 300), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm status8", 32'(bus8.game_status), 32'(ST_ARM));
        chk("arm status3", 32'(bus3.game_status), 32'(ST_ARM));
        // a guess during ARM must be ignored
        guess_trigger = 1'b1;
        user_number   = tgt;
        tick();
        guess_trigger = 1'b0;
        chk("play status8", 32'(bus8.game_status), 32'(ST_PLAY));
        chk("play status3", 32'(bus3.game_status), 32'(ST_PLAY));
        chk("arm guess hv8", 32'(bus8.hint_valid), 32'd0);
        chk("target8", 32'(bus8.actual_number), 32'(tgt));
        chk("target3", 32'(bus3.actual_number), 32'(tgt));
        chk("tries8 full", 32'(bus8.tries_left), 32'd8);
        chk("tries3 full", 32'(bus3.tries_left), 32'd3);
        chk("play over8", 32'(bus8.game_over), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [6:0] exp_tgt;

        //          new  trig num    hv8  h8            t8  ov8 w8  hv3  h3            t3  ov3 w3
        vecs[0]  = '{1'b1, 1'b0, 7'd42, 1'b0, HINT_REJECT,  4'd0, 1'b0, 1'b0, 1'b0, HINT_REJECT,  2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 7'd10, 1'b1, HINT_UP,      4'd7, 1'b0, 1'b0, 1'b1, HINT_UP,      2'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 7'd20, 1'b1, HINT_UP,      4'd6, 1'b0, 1'b0, 1'b1, HINT_UP,      2'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 7'd0,  1'b0, HINT_UP,      4'd6, 1'b0, 1'b0, 1'b0, HINT_UP,      2'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 7'd30, 1'b1, HINT_UP,      4'd5, 1'b0, 1'b0, 1'b1, HINT_UP,      2'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 7'd50, 1'b1, HINT_DOWN,    4'd4, 1'b0, 1'b0, 1'b0, HINT_UP,      2'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 7'd42, 1'b1, HINT_CORRECT, 4'd3, 1'b1, 1'b1, 1'b0, HINT_UP,      2'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 7'd42, 1'b0, HINT_CORRECT, 4'd3, 1'b1, 1'b1, 1'b0, HINT_UP,      2'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 7'd42, 1'b0, HINT_REJECT,  4'd0, 1'b0, 1'b0, 1'b0, HINT_REJECT,  2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 7'd30, 1'b1, HINT_UP,      4'd7, 1'b0, 1'b0, 1'b1, HINT_UP,      2'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 7'd50, 1'b1, HINT_DOWN,    4'd6, 1'b0, 1'b0, 1'b1, HINT_DOWN,    2'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 7'd42, 1'b1, HINT_CORRECT, 4'd5, 1'b1, 1'b1, 1'b1, HINT_CORRECT, 2'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 7'd42, 1'b0, HINT_REJECT,  4'd0, 1'b0, 1'b0, 1'b0, HINT_REJECT,  2'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 7'd50, 1'b1, HINT_DOWN,    4'd7, 1'b0, 1'b0, 1'b1, HINT_DOWN,    2'd2, 1'b0, 1'b0};
`ifdef GUESS_RANGE_NARROW_EN
        vecs[14] = '{1'b0, 1'b1, 7'd60, 1'b1, HINT_REJECT,  4'd7, 1'b0, 1'b0, 1'b1, HINT_REJECT,  2'd2, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 7'd45, 1'b1, HINT_DOWN,    4'd6, 1'b0, 1'b0, 1'b1, HINT_DOWN,    2'd1, 1'b0, 1'b0};
`else
        vecs[14] = '{1'b0, 1'b1, 7'd60, 1'b1, HINT_DOWN,    4'd6, 1'b0, 1'b0, 1'b1, HINT_DOWN,    2'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 7'd45, 1'b1, HINT_DOWN,    4'd5, 1'b0, 1'b0, 1'b1, HINT_DOWN,    2'd0, 1'b1, 1'b0};
`endif

        reset         = 1'b1;
        start         = 1'b0;
        guess_trigger = 1'b0;
        user_number   = 7'd0;
        tick();
        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b0;

        // guess while IDLE is ignored
        guess_trigger = 1'b1;
        user_number   = 7'd5;
        tick();
        guess_trigger = 1'b0;
        tick();
        check_reset_values("idle guess");

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].new_round) begin
                start_round(vecs[i].num);
            end else begin
                guess_trigger = vecs[i].trig;
                user_number   = vecs[i].num;
                tick();
                guess_trigger = 1'b0;
                chk($sformatf("row%0d hv8", i), 32'(bus8.hint_valid), 32'(vecs[i].hv8));
                chk($sformatf("row%0d hintcode_m8", i), 32'(bus8.hint), 32'(vecs[i].h8));
                chk($sformatf("row%0d tries8", i), 32'(bus8.tries_left), 32'(vecs[i].t8));
                chk($sformatf("row%0d over8", i), 32'(bus8.game_over), 32'(vecs[i].ov8));
                chk($sformatf("row%0d win8", i), 32'(bus8.win), 32'(vecs[i].w8));
                chk($sformatf("row%0d status8", i), 32'(bus8.game_status), 32'(exp_state(vecs[i].ov8, vecs[i].w8)));
                chk($sformatf("row%0d hv3", i), 32'(bus3.hint_valid), 32'(vecs[i].hv3));
                chk($sformatf("row%0d hintcode_m3", i), 32'(bus3.hint), 32'(vecs[i].h3));
                chk($sformatf("row%0d tries3", i), 32'(bus3.tries_left), 32'(vecs[i].t3));
                chk($sformatf("row%0d over3", i), 32'(bus3.game_over), 32'(vecs[i].ov3));
                chk($sformatf("row%0d win3", i), 32'(bus3.win), 32'(vecs[i].w3));
                chk($sformatf("row%0d status3", i), 32'(bus3.game_status), 32'(exp_state(vecs[i].ov3, vecs[i].w3)));
            end
        end

        // start and guess in the same cycle: start wins, a fresh target is latched
        start         = 1'b1;
        guess_trigger = 1'b1;
        user_number   = 7'd42;
        tick();
        start         = 1'b0;
        guess_trigger = 1'b0;
        exp_tgt       = m_lfsr;
        chk("collide hv8", 32'(bus8.hint_valid), 32'd0);
        chk("collide hv3", 32'(bus3.hint_valid), 32'd0);
        chk("collide status8", 32'(bus8.game_status), 32'(ST_ARM));
        tick();
        chk("collide play8", 32'(bus8.game_status), 32'(ST_PLAY));
        chk("collide play3", 32'(bus3.game_status), 32'(ST_PLAY));
        chk("collide tries8", 32'(bus8.tries_left), 32'd8);
        chk("collide tries3", 32'(bus3.tries_left), 32'd3);
        chk("collide target8", 32'(bus8.actual_number), 32'(exp_tgt));
        chk("collide hv8 after", 32'(bus8.hint_valid), 32'd0);

        // reset in the cycle the hint would appear drops it and aborts the round
        guess_trigger = 1'b1;
        user_number   = 7'd1;
        tick();
        guess_trigger = 1'b0;
        reset         = 1'b1;
        #1;
        chk("abort hv8", 32'(bus8.hint_valid), 32'd0);
        chk("abort hv3", 32'(bus3.hint_valid), 32'd0);
        tick();
        check_reset_values("abort");
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/guess_game_engine.md
GUESS_GAME_ENGINE -- requirements
Module: guess_game_engine

Interface
REQ-001 Parameter WIDTH, default 7, bit width of guesses and target (range 1..2^WIDTH-1).
REQ-002 Parameter MAX_TRIES, default 8, guesses allowed per round (1..255).
REQ-003 Parameter SEED, default 1 (nonzero, WIDTH bits), LFSR reset value.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a new round from any state.
REQ-007 guess_trigger  in  1  one-cycle pulse; user_number valid this cycle.
REQ-008 user_number  in  WIDTH  player guess.
REQ-009 hint  out  2  00 REJECT, 01 UP (target greater), 10 DOWN (target smaller), 11 CORRECT.
REQ-010 hint_valid  out  1  one-cycle pulse qualifying hint.
REQ-011 tries_left  out  $clog2(MAX_TRIES+1)  remaining guesses this round.
REQ-012 game_over  out  1  high in WIN or LOSE.
REQ-013 win  out  1  high in WIN only.
REQ-014 actual_number  out  WIDTH  current target, registered.
REQ-015 game_status  out  3  current FSM state encoding.

Function
REQ-016 FSM states IDLE, ARM, PLAY, WIN, LOSE; encodings from package.
REQ-017 LFSR (maximal-length, WIDTH bits) SHALL advance every cycle, never reaching zero.
REQ-018 start in any state -> ARM next cycle; ARM latches LFSR value into actual_number, loads tries_left=MAX_TRIES, -> PLAY next cycle.
REQ-019 In PLAY, guess_trigger registers compare; hint/hint_valid SHALL appear exactly 1 cycle later.
REQ-020 Comparison unsigned, WIDTH bits: guess<target -> UP, guess>target -> DOWN, equal -> CORRECT.
REQ-021 Each accepted guess decrements tries_left by 1 in the same cycle hint_valid asserts.
REQ-022 CORRECT -> WIN; otherwise tries_left reaching 0 -> LOSE; CORRECT on last try -> WIN.
REQ-023 WIN/LOSE hold, game_over=1, until start or reset.
REQ-024 guess_trigger in IDLE, ARM, WIN, LOSE SHALL be ignored: no hint_valid, no try consumed.
REQ-025 start and guess_trigger in the same cycle: start wins, guess discarded, no hint_valid.
REQ-026 guess_trigger on consecutive cycles SHALL each be processed (throughput 1 guess/cycle).
REQ-027 hint holds last value between pulses; hint_valid is the only qualifier.

Reset
REQ-028 reset: state=IDLE, hint=00, hint_valid=0, tries_left=0, game_over=0, win=0, actual_number=0, LFSR=SEED.
REQ-029 reset asserted mid-round SHALL abort the round immediately; an in-flight hint is dropped.

Configuration
REQ-030 Macro GUESS_RANGE_NARROW_EN: when defined, engine tracks bounds lo/hi (ARM: lo=1, hi=2^WIDTH-1); UP sets lo=guess+1, DOWN sets hi=guess-1.
REQ-031 With the macro, a guess outside [lo,hi] SHALL return hint=REJECT with hint_valid and SHALL NOT consume a try.
REQ-032 Without the macro, no bounds exist, REJECT is never produced, every PLAY guess consumes a try.

Structure
REQ-033 Package guess_game_pkg SHALL hold the state typedef/encodings and hint constants (HINT_REJECT, HINT_UP, HINT_DOWN, HINT_CORRECT).
REQ-034 Sub-module guess_lfsr (parameters WIDTH, SEED) SHALL implement the random source.

Verification
REQ-035 WIDTH=7, start, read actual_number=42; guess 30 -> UP, 50 -> DOWN, 42 -> CORRECT, win=1, game_over=1, tries_left=5.
REQ-036 MAX_TRIES=3, target 42, guesses 10,20,30 -> three UP, then LOSE, win=0, game_over=1; 4th guess -> no hint_valid.
REQ-037 PLAY, start and guess_trigger same cycle -> no hint_valid, ARM then PLAY, tries_left=MAX_TRIES, new target latched.
REQ-038 reset asserted one cycle after guess_trigger -> no hint_valid, all outputs at REQ-028 values next cycle.
REQ-039 GUESS_RANGE_NARROW_EN, target 42: guess 50 -> DOWN (hi=49); guess 60 -> REJECT, tries_left unchanged at MAX_TRIES-1.
REQ-040 Guesses on 3 consecutive cycles -> 3 consecutive hint_valid pulses, tries_left decrementing each cycle.
